// File: rtl/prach_buffer_sched.sv
// prach_buffer_sched: round-robin readout scheduler for a bank of PRACH
// capture buffers. Grants one full buffer at a time, drives the shared read
// address plus a one-hot read enable, and re-serialises the returned words
// into a single tagged sample stream.
module prach_buffer_sched #(
    parameter int NUM_CH  = 4,
    parameter int BUF_LEN = 1536,
    parameter int RD_LAT  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     done_req,
    output logic [NUM_CH-1:0]     done_ack,
    output logic [10:0]           rd_addr,
    output logic [NUM_CH-1:0]     rd_en,
    input  logic [32*NUM_CH-1:0]  rd_data,
    input  logic [NUM_CH-1:0]     ctrl_ch_en,
    input  logic                  dout_rdy,
    output logic [15:0]           dout_dr,
    output logic [15:0]           dout_di,
    output logic                  dout_dv,
    output logic [7:0]            dout_chn,
    output logic                  dout_first,
    output logic                  dout_last,
    output logic                  busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(RD_LAT + 2);
    localparam logic [10:0]      ADDR_LAST  = 11'(BUF_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT);
    localparam logic [CH_W-1:0]  CH_MAX     = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_READ,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    sel_q, sel_d;
    logic [CH_W-1:0]    last_q, last_d;
    logic [10:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic [NUM_CH-1:0]  ack_q, ack_d;

    logic [NUM_CH-1:0]  pend;
    logic               hi_vld, pick_vld;
    logic [CH_W-1:0]    hi_ch, lo_ch, pick_ch;
    logic               issue;

    // Delay line tracking each issued read until its data is at rd_data
    logic [RD_LAT-1:0]            dl_vld_q, dl_first_q, dl_last_q;
    logic [RD_LAT-1:0][CH_W-1:0]  dl_chn_q;
    logic                         end_vld;
    logic [CH_W-1:0]              end_chn;
    logic [31:0]                  rd_word;

    logic [15:0] dout_dr_q, dout_di_q;
    logic        dout_dv_q, dout_first_q, dout_last_q;
    logic [7:0]  dout_chn_q;

    // Round-robin pick: lowest pending channel above last, else lowest overall.
    // A channel acked last cycle is masked so its still-high request is not
    // taken twice before the buffer has had a chance to drop it.
    always_comb begin
        pend   = done_req & ~ack_q;
        hi_vld = 1'b0;
        hi_ch  = '0;
        pick_vld = 1'b0;
        lo_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i] && (i > int'(last_q))) begin
                hi_vld = 1'b1;
                hi_ch  = CH_W'(i);
            end
            if (pend[i]) begin
                pick_vld = 1'b1;
                lo_ch    = CH_W'(i);
            end
        end
        pick_ch = hi_vld ? hi_ch : lo_ch;
    end

    // Next-state logic for the grant / read / drain sequence
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        ack_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    if (!ctrl_ch_en[pick_ch]) begin
                        // disabled channel: acknowledge and discard, no readout
                        ack_d[pick_ch] = 1'b1;
                        last_d         = pick_ch;
                    end else if (dout_rdy) begin
                        ack_d[pick_ch] = 1'b1;
                        sel_d          = pick_ch;
                        last_d         = pick_ch;
                        state_d        = S_GRANT;
                    end
                end
            end
            S_GRANT: begin
                addr_d  = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (addr_q == ADDR_LAST) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 11'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scheduler state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= CH_MAX;
            addr_q  <= '0;
            drain_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            ack_q   <= ack_d;
        end
    end

    assign issue    = (state_q == S_READ);
    assign done_ack = ack_q;
    assign rd_addr  = addr_q;
    assign busy     = (state_q != S_IDLE);

    // One-hot read enable for the granted buffer while reading
    always_comb begin
        rd_en = '0;
        if (issue) begin
            rd_en[sel_q] = 1'b1;
        end
    end

    // Delay line: valid/first/last/channel follow each read for RD_LAT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld_q   <= '0;
            dl_first_q <= '0;
            dl_last_q  <= '0;
            dl_chn_q   <= '0;
        end else begin
            dl_vld_q[0]   <= issue;
            dl_first_q[0] <= issue && (addr_q == 11'd0);
            dl_last_q[0]  <= issue && (addr_q == ADDR_LAST);
            dl_chn_q[0]   <= issue ? sel_q : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_vld_q[i]   <= dl_vld_q[i-1];
                dl_first_q[i] <= dl_first_q[i-1];
                dl_last_q[i]  <= dl_last_q[i-1];
                dl_chn_q[i]   <= dl_chn_q[i-1];
            end
        end
    end

    assign end_vld = dl_vld_q[RD_LAT-1];
    assign end_chn = dl_chn_q[RD_LAT-1];

    // Select the returning word of the channel at the end of the delay line
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (end_chn == CH_W'(c)) begin
                rd_word = rd_data[32*c +: 32];
            end
        end
    end

    // Output register: sample fields forced to zero when not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dv_q    <= 1'b0;
            dout_first_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_chn_q   <= '0;
            dout_dr_q    <= '0;
            dout_di_q    <= '0;
        end else begin
            dout_dv_q    <= end_vld;
            dout_first_q <= end_vld && dl_first_q[RD_LAT-1];
            dout_last_q  <= end_vld && dl_last_q[RD_LAT-1];
            dout_chn_q   <= end_vld ? 8'(end_chn) : 8'd0;
            dout_di_q    <= end_vld ? rd_word[31:16] : 16'd0;
            dout_dr_q    <= end_vld ? rd_word[15:0] : 16'd0;
        end
    end

    assign dout_dv    = dout_dv_q;
    assign dout_first = dout_first_q;
    assign dout_last  = dout_last_q;
    assign dout_chn   = dout_chn_q;
    assign dout_di    = dout_di_q;
    assign dout_dr    = dout_dr_q;

endmodule

// File: tb/tb_prach_buffer_sched.sv
// Directed bench for prach_buffer_sched with a simple buffer model that
// returns a channel-tagged address word RD_LAT cycles after each read.
`timescale 1ns/1ps
module tb_prach_buffer_sched;

    localparam int NUM_CH  = 4;
    localparam int BUF_LEN = 1536;
    localparam int RD_LAT  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    done_req;
    logic [NUM_CH-1:0]    done_ack;
    logic [10:0]          rd_addr;
    logic [NUM_CH-1:0]    rd_en;
    logic [32*NUM_CH-1:0] rd_data;
    logic [NUM_CH-1:0]    ctrl_ch_en;
    logic                 dout_rdy;
    logic [15:0]          dout_dr, dout_di;
    logic                 dout_dv, dout_first, dout_last, busy;
    logic [7:0]           dout_chn;

    int vec  = 0;
    int miss = 0;

    logic [10:0]       hist [RD_LAT];
    logic [NUM_CH-1:0] s_ack;
    logic [10:0]       s_addr;

    prach_buffer_sched #(.NUM_CH(NUM_CH), .BUF_LEN(BUF_LEN), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .done_req(done_req), .done_ack(done_ack),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .ctrl_ch_en(ctrl_ch_en),
        .dout_rdy(dout_rdy), .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv),
        .dout_chn(dout_chn), .dout_first(dout_first), .dout_last(dout_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Buffer word for channel c at address a: di = {c, 0, a}, dr = ~di
    function automatic logic [31:0] exp_word(input int c, input logic [10:0] a);
        logic [15:0] di;
        di = {4'(c), 1'b0, a};
        return {di, ~di};
    endfunction

    // Advance one cycle; returns #1 after the rising edge. Models the buffers:
    // requests drop after an ack, data follows the read address by RD_LAT.
    task automatic tick();
        @(negedge clk);
        s_ack  = done_ack;
        s_addr = rd_addr;
        @(posedge clk);
        #1;
        for (int i = RD_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0]  = s_addr;
        done_req = done_req & ~s_ack;
        for (int c = 0; c < NUM_CH; c++) rd_data[32*c +: 32] = exp_word(c, hist[RD_LAT-1]);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        done_req   = '0;
        ctrl_ch_en = '1;
        dout_rdy   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [70:0] outs;
        rst_n = 1'b0;
        tick();
        outs = {done_ack, rd_addr, rd_en, dout_dr, dout_di, dout_dv, dout_chn, dout_first, dout_last, busy};
        vec++;
        if (outs !== '0) begin
            miss++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        rst_n = 1'b1;
        tick();
        tick();
        outs = {done_ack, rd_addr, rd_en, dout_dr, dout_di, dout_dv, dout_chn, dout_first, dout_last, busy};
        vec++;
        if (outs !== '0) begin
            miss++;
            $display("FAIL idle_after_reset got %h want 0", outs);
        end
    endtask

    task automatic test_single();
        logic [3:0]  e_ack, e_en;
        logic        e_dv;
        logic [31:0] e_word;
        do_reset();
        dout_rdy = 1'b1;
        done_req = 4'b0100;
        for (int k = 1; k <= 1546; k++) begin
            tick();
            e_ack  = (k == 1) ? 4'b0100 : 4'b0000;
            e_en   = (k >= 2 && k <= 1537) ? 4'b0100 : 4'b0000;
            e_dv   = (k >= 6 && k <= 1541);
            e_word = e_dv ? exp_word(2, 11'(k - 6)) : 32'h0;
            vec++;
            if (done_ack !== e_ack) begin
                miss++;
                $display("FAIL single_ack k=%0d got %b want %b", k, done_ack, e_ack);
            end
            vec++;
            if (rd_en !== e_en) begin
                miss++;
                $display("FAIL single_rd_en k=%0d got %b want %b", k, rd_en, e_en);
            end
            if (e_en != 4'b0000) begin
                vec++;
                if (rd_addr !== 11'(k - 2)) begin
                    miss++;
                    $display("FAIL single_rd_addr k=%0d got %0d want %0d", k, rd_addr, k - 2);
                end
            end
            vec++;
            if (dout_dv !== e_dv) begin
                miss++;
                $display("FAIL single_dv k=%0d got %b want %b", k, dout_dv, e_dv);
            end
            vec++;
            if ({dout_di, dout_dr} !== e_word) begin
                miss++;
                $display("FAIL single_data k=%0d got %h want %h", k, {dout_di, dout_dr}, e_word);
            end
            vec++;
            if (dout_first !== (k == 6)) begin
                miss++;
                $display("FAIL single_first k=%0d got %b", k, dout_first);
            end
            vec++;
            if (dout_last !== (k == 1541)) begin
                miss++;
                $display("FAIL single_last k=%0d got %b", k, dout_last);
            end
            vec++;
            if (dout_chn !== (e_dv ? 8'd2 : 8'd0)) begin
                miss++;
                $display("FAIL single_chn k=%0d got %0d", k, dout_chn);
            end
            if (k != 1542) begin
                vec++;
                if (busy !== (k <= 1541)) begin
                    miss++;
                    $display("FAIL single_busy k=%0d got %b", k, busy);
                end
            end
        end
    endtask

    task automatic test_all_four();
        logic [3:0] seq [8];
        int fcyc [4];
        int lcyc [4];
        int n, nf, nl, ndv;
        do_reset();
        dout_rdy = 1'b1;
        done_req = 4'b1111;
        n = 0; nf = 0; nl = 0; ndv = 0;
        for (int k = 1; k <= 6200; k++) begin
            tick();
            if (done_ack != 4'b0000) begin
                if (n < 8) seq[n] = done_ack;
                n++;
            end
            if (dout_first) begin
                if (nf < 4) fcyc[nf] = k;
                nf++;
            end
            if (dout_last) begin
                if (nl < 4) lcyc[nl] = k;
                nl++;
            end
            if (dout_dv) ndv++;
        end
        vec++;
        if (n != 4) begin
            miss++;
            $display("FAIL all4_ack_count got %0d want 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                vec++;
                if (seq[i] !== 4'(1 << i)) begin
                    miss++;
                    $display("FAIL all4_order idx=%0d got %b want %b", i, seq[i], 4'(1 << i));
                end
            end
        end
        vec++;
        if (ndv != 4 * BUF_LEN) begin
            miss++;
            $display("FAIL all4_dv_count got %0d want %0d", ndv, 4 * BUF_LEN);
        end
        vec++;
        if (nf != 4 || nl != 4) begin
            miss++;
            $display("FAIL all4_markers got first=%0d last=%0d want 4/4", nf, nl);
        end else begin
            vec++;
            if (fcyc[0] != 6) begin
                miss++;
                $display("FAIL all4_first_latency got %0d want 6", fcyc[0]);
            end
            for (int i = 1; i < 4; i++) begin
                vec++;
                if (fcyc[i] - lcyc[i-1] != 7) begin
                    miss++;
                    $display("FAIL all4_gap blk=%0d got %0d want 7", i, fcyc[i] - lcyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_rr_wrap();
        logic [3:0] seq [4];
        int n;
        n = 0;
        done_req = 4'b1001;
        for (int k = 1; k <= 3100; k++) begin
            tick();
            if (done_ack != 4'b0000) begin
                if (n < 4) seq[n] = done_ack;
                n++;
            end
        end
        vec++;
        if (n != 2) begin
            miss++;
            $display("FAIL wrap_ack_count got %0d want 2", n);
        end else begin
            vec++;
            if (seq[0] !== 4'b0001) begin
                miss++;
                $display("FAIL wrap_first got %b want 0001", seq[0]);
            end
            vec++;
            if (seq[1] !== 4'b1000) begin
                miss++;
                $display("FAIL wrap_second got %b want 1000", seq[1]);
            end
        end
    endtask

    task automatic test_disable();
        int n_en1, n_dv2, n_dvx;
        do_reset();
        ctrl_ch_en = 4'b1101;
        dout_rdy   = 1'b0;
        done_req   = 4'b0110;
        n_en1 = 0; n_dv2 = 0; n_dvx = 0;
        for (int k = 1; k <= 1560; k++) begin
            tick();
            if (rd_en[1]) n_en1++;
            if (dout_dv && dout_chn == 8'd2) n_dv2++;
            if (dout_dv && dout_chn != 8'd2) n_dvx++;
            if (k == 1) begin
                vec++;
                if (done_ack !== 4'b0010 || busy !== 1'b0) begin
                    miss++;
                    $display("FAIL disable_discard_ack got ack=%b busy=%b want 0010/0", done_ack, busy);
                end
            end
            if (k == 2) begin
                vec++;
                if (done_ack !== 4'b0000 || busy !== 1'b0) begin
                    miss++;
                    $display("FAIL disable_wait_rdy got ack=%b busy=%b want 0000/0", done_ack, busy);
                end
                dout_rdy = 1'b1;
            end
            if (k == 3) begin
                vec++;
                if (done_ack !== 4'b0100 || busy !== 1'b1) begin
                    miss++;
                    $display("FAIL disable_grant2 got ack=%b busy=%b want 0100/1", done_ack, busy);
                end
            end
            if (k == 4) begin
                vec++;
                if (rd_en !== 4'b0100 || rd_addr !== 11'd0) begin
                    miss++;
                    $display("FAIL disable_read2 got en=%b addr=%0d want 0100/0", rd_en, rd_addr);
                end
            end
        end
        vec++;
        if (n_en1 != 0) begin
            miss++;
            $display("FAIL disable_no_read1 got %0d want 0", n_en1);
        end
        vec++;
        if (n_dv2 != BUF_LEN || n_dvx != 0) begin
            miss++;
            $display("FAIL disable_stream got ch2=%0d other=%0d want %0d/0", n_dv2, n_dvx, BUF_LEN);
        end
    endtask

    task automatic test_rdy();
        int n_bad;
        do_reset();
        dout_rdy = 1'b0;
        done_req = 4'b0001;
        n_bad = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            vec++;
            if (done_ack !== 4'b0000 || busy !== 1'b0) begin
                miss++;
                $display("FAIL rdy_hold k=%0d got ack=%b busy=%b want 0000/0", k, done_ack, busy);
            end
        end
        dout_rdy = 1'b1;
        tick();
        vec++;
        if (done_ack !== 4'b0001 || busy !== 1'b1) begin
            miss++;
            $display("FAIL rdy_grant got ack=%b busy=%b want 0001/1", done_ack, busy);
        end
        tick();
        vec++;
        if (rd_en !== 4'b0001 || rd_addr !== 11'd0) begin
            miss++;
            $display("FAIL rdy_read got en=%b addr=%0d want 0001/0", rd_en, rd_addr);
        end
    endtask

    task automatic test_reset_mid();
        logic [70:0] outs;
        do_reset();
        dout_rdy = 1'b1;
        done_req = 4'b0010;
        repeat (702) tick();
        vec++;
        if (rd_en !== 4'b0010 || rd_addr !== 11'd700 || dout_dv !== 1'b1 || busy !== 1'b1) begin
            miss++;
            $display("FAIL midrst_pre got en=%b addr=%0d dv=%b busy=%b want 0010/700/1/1",
                     rd_en, rd_addr, dout_dv, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (rd_en !== 4'b0000 || dout_dv !== 1'b0 || busy !== 1'b0) begin
            miss++;
            $display("FAIL midrst_async got en=%b dv=%b busy=%b want 0000/0/0", rd_en, dout_dv, busy);
        end
        done_req = 4'b0010;
        tick();
        tick();
        outs = {done_ack, rd_addr, rd_en, dout_dr, dout_di, dout_dv, dout_chn, dout_first, dout_last, busy};
        vec++;
        if (outs !== '0) begin
            miss++;
            $display("FAIL midrst_held got %h want 0", outs);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                vec++;
                if (done_ack !== 4'b0010) begin
                    miss++;
                    $display("FAIL midrst_regrant got %b want 0010", done_ack);
                end
            end
            if (k == 2) begin
                vec++;
                if (rd_en !== 4'b0010 || rd_addr !== 11'd0) begin
                    miss++;
                    $display("FAIL midrst_restart got en=%b addr=%0d want 0010/0", rd_en, rd_addr);
                end
            end
            if (k <= 5) begin
                vec++;
                if (dout_dv !== 1'b0) begin
                    miss++;
                    $display("FAIL midrst_no_partial k=%0d got dv=%b want 0", k, dout_dv);
                end
            end else begin
                vec++;
                if (dout_dv !== 1'b1 || dout_first !== 1'b1 || dout_chn !== 8'd1 ||
                    {dout_di, dout_dr} !== exp_word(1, 11'd0)) begin
                    miss++;
                    $display("FAIL midrst_first got dv=%b first=%b chn=%0d data=%h want 1/1/1/%h",
                             dout_dv, dout_first, dout_chn, {dout_di, dout_dr}, exp_word(1, 11'd0));
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        done_req   = '0;
        ctrl_ch_en = '1;
        dout_rdy   = 1'b0;
        rd_data    = '0;
        for (int i = 0; i < RD_LAT; i++) hist[i] = '0;
        test_reset();
        test_single();
        test_all_four();
        test_rr_wrap();
        test_disable();
        test_rdy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
